// File: rtl/pe_seq_ctrl.sv
// Sequencer for the 8-in/2-out processing element: issues group reads, feeds the PE,
// and tracks each group through the PE latency to write its result back.
module pe_seq_ctrl #(
    parameter int SWORD_LEN = 16,
    parameter int WWORD_LEN = 32,
    parameter int NEU_IN    = 8,
    parameter int NEU_OUT   = 2,
    parameter int ADDR_W    = 8,
    parameter int PE_LAT    = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [ADDR_W-1:0]                           NGRP,
    input  logic                                        hold,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        rd_en,
    output logic [ADDR_W-1:0]                           RADDR,
    input  logic [SWORD_LEN*NEU_IN-1:0]                 RDATA,
    input  logic [SWORD_LEN*NEU_IN+WWORD_LEN*NEU_IN-1:0] RWEIGHT,
    output logic                                        pe_ce,
    output logic [SWORD_LEN*NEU_IN-1:0]                 PE_DATA,
    output logic [SWORD_LEN*NEU_IN+WWORD_LEN*NEU_IN-1:0] PE_WEIGHT,
    input  logic [NEU_OUT*WWORD_LEN-1:0]                PE_Q,
    output logic                                        wr_en,
    output logic [ADDR_W-1:0]                           WADDR,
    output logic [NEU_OUT*WWORD_LEN-1:0]                WDATA
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    // Stage 1: read data arriving, stage 2: PE inputs valid, stage STG: PE_Q valid.
    localparam int STG = 2 + PE_LAT;

    logic [1:0]                                  r_state;
    logic [ADDR_W-1:0]                           r_ngrp;
    logic [ADDR_W:0]                             r_cnt;
    logic [STG:1]                                r_vld;
    logic [STG:1][ADDR_W-1:0]                    r_tag;
    logic                                        r_wr_en;
    logic [ADDR_W-1:0]                           r_waddr;
    logic [SWORD_LEN*NEU_IN-1:0]                 r_pe_data;
    logic [SWORD_LEN*NEU_IN+WWORD_LEN*NEU_IN-1:0] r_pe_weight;
    logic [NEU_OUT*WWORD_LEN-1:0]                r_wdata;

    logic              w_issue;
    logic [ADDR_W:0]   w_cnt_nxt;

    assign w_issue   = (r_state == S_ISSUE) && !hold;
    assign w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ngrp  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_ngrp  <= NGRP;
                    r_cnt   <= '0;
                    r_state <= (NGRP == '0) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: if (w_issue) begin
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == {1'b0, r_ngrp}) r_state <= S_DRAIN;
                end
                // The final write is in its output register when the pipe empties.
                S_DRAIN: if (r_vld == '0) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_tag       <= '0;
            r_wr_en     <= 1'b0;
            r_waddr     <= '0;
            r_pe_data   <= '0;
            r_pe_weight <= '0;
            r_wdata     <= '0;
        end else begin
            r_vld   <= {r_vld[STG-1:1], w_issue};
            r_tag   <= {r_tag[STG-1:1], RADDR};
            r_wr_en <= r_vld[STG];
            if (r_vld[1]) begin
                r_pe_data   <= RDATA;
                r_pe_weight <= RWEIGHT;
            end
            if (r_vld[STG]) begin
                r_waddr <= r_tag[STG];
                r_wdata <= PE_Q;
            end
        end
    end

    assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign rd_en     = w_issue;
    assign RADDR     = r_cnt[ADDR_W-1:0];
    assign pe_ce     = r_vld[2];
    assign PE_DATA   = r_pe_data;
    assign PE_WEIGHT = r_pe_weight;
    assign wr_en     = r_wr_en;
    assign WADDR     = r_waddr;
    assign WDATA     = r_wdata;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: memory + delay-line PE models, write-back scoreboard,
// table of passes plus a reset-during-drain sequence.
module tb_pe_seq_ctrl;
    localparam int SW = 16, WW = 32, NI = 8, NO = 2, AW = 8, LAT = 2;
    localparam int DW = SW*NI, RW = SW*NI + WW*NI, QW = NO*WW;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
    logic [AW-1:0] NGRP = '0;
    logic busy, done, rd_en, pe_ce, wr_en;
    logic [AW-1:0] RADDR, WADDR;
    logic [DW-1:0] RDATA = '0, PE_DATA;
    logic [RW-1:0] RWEIGHT = '0, PE_WEIGHT;
    logic [QW-1:0] PE_Q, WDATA;
    logic [QW-1:0] q_pipe [LAT];

    int n_vec = 0, n_miss = 0, cyc = 0;
    int n_rd = 0, n_wr = 0, n_busy = 0, n_done = 0, n_ce = 0;

    typedef struct { logic [AW-1:0] addr; int cyc; } sb_t;
    sb_t sb[$];

    typedef struct { int ngrp; int hold_at; int hold_len; int restart_at; int exp_busy; } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pe_seq_ctrl #(.SWORD_LEN(SW), .WWORD_LEN(WW), .NEU_IN(NI), .NEU_OUT(NO),
                  .ADDR_W(AW), .PE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .NGRP(NGRP), .hold(hold),
        .busy(busy), .done(done), .rd_en(rd_en), .RADDR(RADDR),
        .RDATA(RDATA), .RWEIGHT(RWEIGHT), .pe_ce(pe_ce), .PE_DATA(PE_DATA),
        .PE_WEIGHT(PE_WEIGHT), .PE_Q(PE_Q), .wr_en(wr_en), .WADDR(WADDR), .WDATA(WDATA));

    function automatic logic [DW-1:0] mem_d(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int j = 0; j < NI; j++) r[j*SW +: SW] = {a, 8'(j + 1)};
        return r;
    endfunction

    function automatic logic [RW-1:0] mem_w(input logic [AW-1:0] a);
        logic [RW-1:0] r;
        for (int k = 0; k < RW/WW; k++) r[k*WW +: WW] = {8'hA5, a, 16'(k*7 + 1)};
        return r;
    endfunction

    function automatic logic [QW-1:0] pe_f(input logic [DW-1:0] d, input logic [RW-1:0] w);
        return {w[WW-1:0] ^ {16'h0, d[SW-1:0]}, d[DW-1 -: 32] ^ w[RW-1 -: 32]};
    endfunction

    // External memories: one-cycle read latency.
    always @(posedge clk) if (rd_en) begin
        RDATA   <= mem_d(RADDR);
        RWEIGHT <= mem_w(RADDR);
    end

    // PE stand-in: pure delay of LAT cycles on a function of its inputs.
    always @(posedge clk) begin
        if (pe_ce) q_pipe[0] <= pe_f(PE_DATA, PE_WEIGHT);
        for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign PE_Q = q_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (busy)  n_busy++;
        if (done)  n_done++;
        if (pe_ce) n_ce++;
        if (rd_en) begin
            chk("raddr", 64'(RADDR), 64'(n_rd));
            sb.push_back('{addr: RADDR, cyc: cyc});
            n_rd++;
        end
        if (wr_en) begin
            n_wr++;
            if (sb.size() == 0) chk("wr_unexpected", 64'(1), 64'(0));
            else begin
                e = sb.pop_front();
                chk("waddr", 64'(WADDR), 64'(e.addr));
                chk("wdata", WDATA, pe_f(mem_d(e.addr), mem_w(e.addr)));
                chk("wr_lat", 64'(cyc - e.cyc), 64'(LAT + 3));
            end
        end
    end

    task automatic clr_counts();
        n_rd = 0; n_wr = 0; n_busy = 0; n_done = 0; n_ce = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 64'({busy, done, rd_en, pe_ce, wr_en}), 64'(0));
        chk({name, "_addr"}, 64'({RADDR, WADDR}), 64'(0));
        chk({name, "_data"}, 64'((|PE_DATA) | (|PE_WEIGHT) | (|WDATA)), 64'(0));
    endtask

    task automatic run_pass(input vec_t v);
        int jd;
        jd = -1;
        clr_counts();
        hold  = (-1 >= v.hold_at) && (-1 < v.hold_at + v.hold_len);
        NGRP  = AW'(v.ngrp);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 400; j++) begin
            hold  = (j >= v.hold_at) && (j < v.hold_at + v.hold_len);
            start = (j == v.restart_at);
            if (start) NGRP = 8'd9;
            @(posedge clk); #1;
            if (n_done != 0) begin jd = j; break; end
        end
        hold = 1'b0; start = 1'b0;
        if (jd < 0) chk("timeout", 64'(1), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        chk("done_cyc", 64'(jd), 64'(v.exp_busy));
        chk("busy_len", 64'(n_busy), 64'(v.exp_busy));
        chk("n_rd", 64'(n_rd), 64'(v.ngrp));
        chk("n_wr", 64'(n_wr), 64'(v.ngrp));
        chk("n_ce", 64'(n_ce), 64'(v.ngrp));
        chk("n_done", 64'(n_done), 64'(1));
        chk("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        // {ngrp, hold_at, hold_len, restart_at, exp_busy}
        vecs.push_back('{1,   -10, 0, -1, 6});
        vecs.push_back('{4,   -10, 0, -1, 9});
        vecs.push_back('{4,     2, 2, -1, 11});
        vecs.push_back('{0,   -10, 0, -1, 0});
        vecs.push_back('{2,     5, 3, -1, 7});
        vecs.push_back('{3,    -1, 2, -1, 9});
        vecs.push_back('{5,   -10, 0,  2, 10});
        vecs.push_back('{255, -10, 0, -1, 260});

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_pass(vecs[i]);

        // Reset while draining a 6-group pass: two writes already out, none after.
        clr_counts();
        NGRP = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_wr", 64'(n_wr), 64'(2));
        rst_n = 1'b0;
        #1;
        chk_zero("drain_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_wr", 64'(n_wr), 64'(2));
        chk("post_rst_done", 64'(n_done), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));
        run_pass('{2, -10, 0, -1, 7});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
